lattice_observer: RTL and testbench

LATTICE_OBSERVER -- requirements
Module: lattice_observer

---
 rtl/lattice_observer.sv | 131 +++++++++++++
 tb/tb_lattice_observer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lattice_observer.sv
// lattice_observer: scans an N x N periodic Ising lattice row by row and reports magnetization and energy.
// Revision 1.0
`default_nettype none

module lattice_observer #(
   parameter int N     = 8,
   parameter int MAG_W = $clog2(N*N) + 2,
   parameter int ENG_W = $clog2(N*N) + 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    rd_en,
   output logic [$clog2(N)-1:0]    rd_addr,
   input  logic [N-1:0]            rd_data,
   output logic                    busy,
   output logic                    done,
   output logic signed [MAG_W-1:0] magnetization,
   output logic signed [ENG_W-1:0] energy
);

   localparam int AW     = $clog2(N);
   localparam int CNT_W  = $clog2(N + 1);
   localparam int UP_W   = $clog2(N*N + 1);
   localparam int ANTI_W = $clog2(2*N*N + 1);
   localparam int CALC_W = ANTI_W + 2;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, WRAP} state_t;

   state_t                    state;
   logic                      pend;
   logic [AW-1:0]             pend_addr;
   logic [UP_W-1:0]           up;
   logic [ANTI_W-1:0]         anti;
   logic [N-1:0]              row0;
   logic [N-1:0]              prev;

   logic [CNT_W-1:0]          row_up;
   logic [CNT_W-1:0]          row_h;
   logic [CNT_W-1:0]          row_v;
   logic [CNT_W-1:0]          wrap_v;
   logic signed [CALC_W-1:0]  mag_calc;
   logic signed [CALC_W-1:0]  eng_calc;

   function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

   assign row_up = popcount(rd_data);
   assign row_h  = popcount(rd_data ^ {rd_data[N-2:0], rd_data[N-1]});
   assign row_v  = popcount(rd_data ^ prev);
   // In WRAP, prev holds row N-1, closing the vertical periodic bond to row 0.
   assign wrap_v = popcount(prev ^ row0);

   assign mag_calc = $signed(CALC_W'(up) << 1) - $signed(CALC_W'(N*N));
   assign eng_calc = $signed((CALC_W'(anti) + CALC_W'(wrap_v)) << 1) - $signed(CALC_W'(2*N*N));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         rd_en         <= 1'b0;
         rd_addr       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         magnetization <= '0;
         energy        <= '0;
         pend          <= 1'b0;
         pend_addr     <= '0;
         up            <= '0;
         anti          <= '0;
         row0          <= '0;
         prev          <= '0;
      end else begin
         done      <= 1'b0;
         pend      <= rd_en;
         pend_addr <= rd_addr;

         if (pend) begin
            up   <= up + UP_W'(row_up);
            anti <= anti + ANTI_W'(row_h) + ((pend_addr != '0) ? ANTI_W'(row_v) : '0);
            if (pend_addr == '0) begin
               row0 <= rd_data;
            end
            prev <= rd_data;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state   <= READ;
                  rd_en   <= 1'b1;
                  rd_addr <= '0;
                  busy    <= 1'b1;
                  up      <= '0;
                  anti    <= '0;
               end
            end
            READ: begin
               if (rd_addr == AW'(N - 1)) begin
                  state   <= DRAIN;
                  rd_en   <= 1'b0;
                  rd_addr <= '0;
               end else begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            DRAIN: begin
               state <= WRAP;
            end
            WRAP: begin
               state         <= IDLE;
               busy          <= 1'b0;
               done          <= 1'b1;
               magnetization <= MAG_W'(mag_calc);
               energy        <= ENG_W'(eng_calc);
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lattice_observer.sv
// tb_lattice_observer: directed scans with a done-triggered scoreboard plus per-cycle handshake checks.
// Revision 1.0
`default_nettype none

module tb_lattice_observer;

   localparam int N = 8;

   typedef struct {
      logic signed [7:0] mag;
      logic signed [8:0] eng;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              rd_en;
   logic [2:0]        rd_addr;
   logic [7:0]        rd_data = 8'h00;
   logic              busy;
   logic              done;
   logic signed [7:0] magnetization;
   logic signed [8:0] energy;

   logic [7:0] lat [N];
   exp_t       sb_q [$];
   int         checks = 0;
   int         errors = 0;

   lattice_observer #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done),
      .magnetization(magnetization), .energy(energy)
   );

   always #5 clk = ~clk;

   // Row memory: one-cycle read latency; garbage when not strobed.
   always @(posedge clk) begin
      rd_data <= rd_en ? lat[rd_addr] : 8'h3C;
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got done=1 required no done");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (magnetization !== e.mag) begin
               errors++;
               $display("FAIL magnetization got %0d required %0d", magnetization, e.mag);
            end
            checks++;
            if (energy !== e.eng) begin
               errors++;
               $display("FAIL energy got %0d required %0d", energy, e.eng);
            end
         end
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, req);
      end
   endtask

   // Runs one scan. On entry with pre_started=1 start is already high at this negedge.
   task automatic scan(input logic [63:0] rows, input int m, input int e,
                       input bit pre_started, input bit chain, input bit dbl_start);
      exp_t x;
      logic [5:0] want;
      for (int r = 0; r < N; r++) lat[r] = rows[r*8 +: 8];
      x.mag = 8'(m);
      x.eng = 9'(e);
      sb_q.push_back(x);
      if (!pre_started) begin
         @(negedge clk);
         start = 1'b1;
      end
      for (int cyc = 1; cyc <= N + 3; cyc++) begin
         @(negedge clk);
         start = (dbl_start && cyc == 3) ? 1'b1 : 1'b0;
         want = {(cyc <= N) ? 1'b1 : 1'b0,
                 (cyc <= N) ? 3'(cyc - 1) : 3'd0,
                 (cyc <= N + 2) ? 1'b1 : 1'b0,
                 (cyc == N + 3) ? 1'b1 : 1'b0};
         check($sformatf("handshake_cyc%0d", cyc), 16'({rd_en, rd_addr, busy, done}), 16'(want));
         if (chain && cyc == N + 3) start = 1'b1;
      end
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("reset_outputs", 16'({rd_en, rd_addr, busy, done}), 16'h0);
      check("reset_mag", 16'(magnetization), 16'h0);
      check("reset_eng", 16'(energy), 16'h0);
      rst_n = 1'b1;

      scan({8{8'hFF}}, 64, -128, 1'b0, 1'b0, 1'b0);
      scan({8{8'h00}}, -64, -128, 1'b0, 1'b1, 1'b0);
      scan({4{8'h55, 8'hAA}}, 0, 128, 1'b1, 1'b0, 1'b0);
      scan({8'hFE, {7{8'hFF}}}, 62, -120, 1'b0, 1'b0, 1'b0);
      scan({4{8'h00, 8'hFF}}, 0, 0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("idle_after_scan", 16'({rd_en, busy, done}), 16'h0);

      // Reset in cycle k+4 of a scan; start held during reset must be ignored.
      for (int r = 0; r < N; r++) lat[r] = 8'hFF;
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rst_mid_outputs", 16'({rd_en, rd_addr, busy, done}), 16'h0);
      check("rst_mid_mag", 16'(magnetization), 16'h0);
      check("rst_mid_eng", 16'(energy), 16'h0);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         check($sformatf("post_rst_idle%0d", cyc), 16'({rd_en, busy, done}), 16'h0);
      end

      scan({8'hFE, {7{8'hFF}}}, 62, -120, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", 16'(sb_q.size()), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
